// File: rtl/sdram_frame_arbiter.sv
// Frame-buffer memory arbiter: interleaves fixed-length camera write bursts and
// display read bursts on one memory port, with per-side wrapping frame pointers.
module sdram_frame_arbiter #(
    parameter int BURST_LEN   = 16,
    parameter int FRAME_WORDS = 76800,
    parameter int FIFO_DEPTH  = 512,
    parameter int LOW_WM      = 64,
    parameter int ADDR_W      = 23,
    parameter int WR_BASE     = 0,
    parameter int RD_BASE     = 0
) (
    input  logic              ctrl_clk,
    input  logic              reset_n,
    input  logic              wr_sof,
    input  logic              new_frame,
    input  logic [8:0]        write_fifo_rdusedw,
    input  logic [31:0]       write_fifo_q,
    output logic              wr_fifo_rdreq,
    input  logic [8:0]        read_fifo_wrusedw,
    output logic              rd_fifo_wrreq,
    output logic [31:0]       rd_fifo_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [6:0]        mem_burstcount,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_read,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_readdatavalid,
    output logic              wr_frame_done,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_CMD   = 2'd2,
        RD_DATA  = 2'd3
    } state_t;

    localparam logic [8:0]        WR_THRESH   = 9'(BURST_LEN);
    localparam logic [8:0]        RD_LIMIT    = 9'(FIFO_DEPTH - BURST_LEN - 1);
    localparam logic [8:0]        LOW_LEVEL   = 9'(LOW_WM);
    localparam logic [6:0]        LAST_BEAT   = 7'(BURST_LEN - 1);
    localparam logic [6:0]        BURST_COUNT = 7'(BURST_LEN);
    localparam logic [ADDR_W-1:0] STEP        = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_END   = ADDR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] WR_OFS      = ADDR_W'(WR_BASE);
    localparam logic [ADDR_W-1:0] RD_OFS      = ADDR_W'(RD_BASE);

    state_t            state_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [6:0]        beat_reg;
    logic              last_grant_reg;   // 1 = last grant went to read
    logic              wr_rewind_reg;
    logic              rd_rewind_reg;

    logic              wr_eligible;
    logic              rd_eligible;
    logic              rd_urgent;
    logic              grant_rd;
    logic              grant_wr;
    logic              beat_last;
    logic [ADDR_W-1:0] wr_ptr_adv;
    logic [ADDR_W-1:0] rd_ptr_adv;
    logic              wr_wrap;
    logic              rd_wrap;
    logic [ADDR_W-1:0] wr_ptr_done;
    logic [ADDR_W-1:0] rd_ptr_done;
    logic [ADDR_W-1:0] wr_ptr_idle;
    logic [ADDR_W-1:0] rd_ptr_idle;

    assign wr_eligible = write_fifo_rdusedw >= WR_THRESH;
    assign rd_eligible = read_fifo_wrusedw <= RD_LIMIT;
    assign rd_urgent   = rd_eligible & (read_fifo_wrusedw < LOW_LEVEL);
    assign grant_rd    = rd_urgent | (rd_eligible & (~wr_eligible | ~last_grant_reg));
    assign grant_wr    = wr_eligible & ~grant_rd;

    assign beat_last   = beat_reg == LAST_BEAT;

    // A rewind pulse arriving on the completion cycle itself counts as pending.
    assign wr_ptr_adv  = wr_ptr_reg + STEP;
    assign rd_ptr_adv  = rd_ptr_reg + STEP;
    assign wr_wrap     = wr_ptr_adv == FRAME_END;
    assign rd_wrap     = rd_ptr_adv == FRAME_END;
    assign wr_ptr_done = (wr_wrap | wr_sof | wr_rewind_reg) ? '0 : wr_ptr_adv;
    assign rd_ptr_done = (rd_wrap | new_frame | rd_rewind_reg) ? '0 : rd_ptr_adv;

    // In IDLE a rewind applies at once, including to a burst granted that cycle.
    assign wr_ptr_idle = wr_sof ? '0 : wr_ptr_reg;
    assign rd_ptr_idle = new_frame ? '0 : rd_ptr_reg;

    assign wr_fifo_rdreq  = mem_write & ~mem_waitrequest;
    assign mem_writedata  = mem_write ? write_fifo_q : '0;
    assign rd_fifo_wrreq  = (state_reg == RD_DATA) & mem_readdatavalid;
    assign rd_fifo_data   = rd_fifo_wrreq ? mem_readdata : '0;
    assign mem_burstcount = (mem_write | mem_read) ? BURST_COUNT : '0;

    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            beat_reg       <= '0;
            last_grant_reg <= 1'b1;
            wr_rewind_reg  <= 1'b0;
            rd_rewind_reg  <= 1'b0;
            mem_address    <= '0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            wr_frame_done  <= 1'b0;
            busy           <= 1'b0;
        end else begin
            wr_frame_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    wr_ptr_reg <= wr_ptr_idle;
                    rd_ptr_reg <= rd_ptr_idle;
                    beat_reg   <= '0;
                    if (grant_rd) begin
                        state_reg      <= RD_CMD;
                        mem_read       <= 1'b1;
                        mem_address    <= RD_OFS + rd_ptr_idle;
                        last_grant_reg <= 1'b1;
                        busy           <= 1'b1;
                    end else if (grant_wr) begin
                        state_reg      <= WR_BURST;
                        mem_write      <= 1'b1;
                        mem_address    <= WR_OFS + wr_ptr_idle;
                        last_grant_reg <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                WR_BURST: begin
                    if (new_frame) rd_ptr_reg <= '0;
                    if (wr_sof) wr_rewind_reg <= 1'b1;
                    if (!mem_waitrequest) begin
                        beat_reg <= beat_reg + 7'd1;
                        if (beat_last) begin
                            state_reg     <= IDLE;
                            mem_write     <= 1'b0;
                            busy          <= 1'b0;
                            wr_ptr_reg    <= wr_ptr_done;
                            wr_frame_done <= wr_wrap;
                            wr_rewind_reg <= 1'b0;
                        end
                    end
                end
                RD_CMD: begin
                    if (wr_sof) wr_ptr_reg <= '0;
                    if (new_frame) rd_rewind_reg <= 1'b1;
                    if (!mem_waitrequest) begin
                        state_reg <= RD_DATA;
                        mem_read  <= 1'b0;
                        beat_reg  <= '0;
                    end
                end
                RD_DATA: begin
                    if (wr_sof) wr_ptr_reg <= '0;
                    if (new_frame) rd_rewind_reg <= 1'b1;
                    if (mem_readdatavalid) begin
                        beat_reg <= beat_reg + 7'd1;
                        if (beat_last) begin
                            state_reg     <= IDLE;
                            busy          <= 1'b0;
                            rd_ptr_reg    <= rd_ptr_done;
                            rd_rewind_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sdram_frame_arbiter.md
# sdram_frame_arbiter

Schedules the single-port frame-buffer memory between the camera write path and the display read path, on the `ctrl_clk` domain. It watches the camera-side write FIFO (`write_fifo_rdusedw`) and the display-side read FIFO (`read_fifo_wrusedw`), then issues fixed-length Avalon-style bursts: write bursts drain the write FIFO into memory, and read bursts refill the read FIFO. It keeps independent write and read frame address counters that wrap at one frame. `new_frame` rewinds the read pointer for each displayed frame.

## Interface
Parameters:
- `BURST_LEN`, 16: words per burst (power of two, ≤ 64).
- `FRAME_WORDS`, 76800: words per frame (320×240); must be a multiple of `BURST_LEN`.
- `FIFO_DEPTH`, 512: depth of both FIFOs.
- `LOW_WM`, 64: read-FIFO level below which reads are urgent.
- `ADDR_W`, 23: memory word-address width.
- `WR_BASE`, 0: frame base address for writes.
- `RD_BASE`, 0: frame base address for reads.

Ports:
- `ctrl_clk` in 1: single clock, 100 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr_sof` in 1: one-cycle pulse, camera start of frame.
- `new_frame` in 1: one-cycle pulse, display start of frame.
- `write_fifo_rdusedw` in 9: write-FIFO fill level.
- `write_fifo_q` in 32: write-FIFO show-ahead data.
- `wr_fifo_rdreq` out 1: write-FIFO read acknowledge.
- `read_fifo_wrusedw` in 9: read-FIFO fill level.
- `rd_fifo_wrreq` out 1: read-FIFO write strobe.
- `rd_fifo_data` out 32: read-FIFO write data.
- `mem_address` out ADDR_W: burst start address.
- `mem_burstcount` out 7: burst length, equal to `BURST_LEN`.
- `mem_write` out 1: write request.
- `mem_writedata` out 32: write data.
- `mem_read` out 1: read request.
- `mem_waitrequest` in 1: memory stall.
- `mem_readdata` in 32: read data.
- `mem_readdatavalid` in 1: read beat valid.
- `wr_frame_done` out 1: one-cycle pulse when the write pointer wraps.
- `busy` out 1: high when the FSM is not in IDLE.

## Operation
States and transitions:
- **IDLE**: choose a grant, or stay in IDLE if no request is eligible.
- **WR_BURST**: transfer `BURST_LEN` write beats, then return to IDLE.
- **RD_CMD**: hold the read command until accepted, then go to RD_DATA.
- **RD_DATA**: collect `BURST_LEN` valid beats, then return to IDLE.

Eligibility and arbitration:
- Write is eligible when `write_fifo_rdusedw ≥ BURST_LEN`.
- Read is eligible when `read_fifo_wrusedw ≤ FIFO_DEPTH − BURST_LEN − 1`.
- If a read is eligible and `read_fifo_wrusedw < LOW_WM`, the read wins.
- Otherwise, if both are eligible, the side not granted last time wins. The `last_grant` register resets to "read", so the first contested grant goes to write.
- Otherwise, the single eligible side wins.

Write burst:
- `mem_write` stays high for the whole burst. `mem_address` and `mem_burstcount` are valid and stable throughout.
- `mem_writedata = write_fifo_q`.
- `wr_fifo_rdreq = mem_write & ~mem_waitrequest`.
- The beat counter advances only on accepted beats. The burst ends after accepted beat `BURST_LEN`.

Read burst:
- `mem_read` stays high until the cycle with `~mem_waitrequest`, then drops.
- `rd_fifo_wrreq = mem_readdatavalid` while in RD_DATA, with `rd_fifo_data = mem_readdata`.
- At most one read burst is outstanding.
- `mem_readdatavalid` outside RD_DATA is ignored.

Address pointers:
- `wr_ptr` and `rd_ptr` are frame offsets, `ADDR_W` bits wide.
- `mem_address` = base + pointer.
- Each pointer advances by `BURST_LEN` when its burst completes.
- When a pointer reaches `FRAME_WORDS` it wraps to 0. The write-side wrap pulses `wr_frame_done`.
- `wr_sof` forces `wr_ptr` to 0 and `new_frame` forces `rd_ptr` to 0. The rewind takes effect at once in IDLE. During a burst of the matching type it is latched and applied at burst completion, replacing the normal advance. Pulses on the other side apply immediately.
- Bursts never cross the frame end, because of the `FRAME_WORDS` multiple rule.

## Timing
Reset values:
- All outputs are 0.
- FSM is in IDLE; `wr_ptr` and `rd_ptr` are 0; `last_grant` is read; pending rewinds are cleared.
- While `reset_n` is low, `mem_address` = 0 (`WR_BASE`).

Latency:
- Eligibility is sampled in IDLE. The grant registers there, and `mem_write` or `mem_read` rises on the next cycle (one cycle from the sampled level to the request).
- With zero wait states, a write burst occupies `BURST_LEN` cycles. At least one IDLE cycle separates consecutive bursts.
- Read occupancy is 1 command cycle plus the memory latency plus `BURST_LEN` data cycles.

Boundaries:
- FIFO levels are sampled only in IDLE. Level changes mid-burst have no effect on the current burst.
- Same-cycle `new_frame` and `rd_ptr` wrap: the result is 0.
- Same-cycle `wr_sof` and write-burst completion: the result is 0, and no `wr_frame_done` pulses unless the pointer was at the frame end.
- Reset mid-burst: outputs drop asynchronously, and any partially transferred data is abandoned.

## Test plan
- **Write-only:** hold `write_fifo_rdusedw` = 16 and `read_fifo_wrusedw` = 500. Expect one write burst at address 0 with 16 `wr_fifo_rdreq` pulses, then the next burst at address 16.
- **Wait states:** during a write burst, assert `mem_waitrequest` on beats 3–5. Expect `wr_fifo_rdreq` low on those cycles, the address held, and exactly 16 accepted beats.
- **Arbitration:** with both sides eligible and `read_fifo_wrusedw` = 200, expect grants of W, R, W, R. Drop `read_fifo_wrusedw` to 40; expect the read granted twice in a row even though the write is eligible.
- **Read path:** issue a read with a data latency of 5 cycles. Expect `mem_read` high until accepted and 16 `rd_fifo_wrreq` pulses carrying `mem_readdata`. A spurious `readdatavalid` while in IDLE produces no write strobe.
- **Wrap:** run 4800 write bursts. Expect `wr_frame_done` pulsed once, with the next address at `WR_BASE` (0).
- **Rewind and reset:** pulse `new_frame` mid read burst at `rd_ptr` = 320. Expect the burst to finish and the next read address to be 0. Deassert `reset_n` during a write burst; expect all outputs to go to 0 immediately and the FSM to restart in IDLE.
